// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state, size encodings and byte-lane helpers for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RMW, RESP} state_t;
    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;
    function automatic logic [15:0] lane_extend(input logic [15:0] w, input logic hi, input logic sgn);
        logic [7:0] b;
        b = hi ? w[15:8] : w[7:0];
        return {{8{sgn & b[7]}}, b};
    endfunction
    function automatic logic [15:0] lane_merge(input logic [15:0] w, input logic [7:0] b, input logic hi);
        return hi ? {b, w[7:0]} : {w[15:8], b};
    endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: selects and extends a load byte, merges a store byte into a read word
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [15:0] i_word,
    input  logic [7:0]  i_byte,
    input  logic        i_hi,
    input  logic        i_signed,
    output logic [15:0] o_load,
    output logic [15:0] o_merged
);
    // pure lane logic, no state
    always_comb begin
        o_load   = lane_extend(i_word, i_hi, i_signed);
        o_merged = lane_merge(i_word, i_byte, i_hi);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: handshaked load/store initiator with byte RMW, extension and range checks
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);
    state_t            r_state, w_next;
    logic              r_we, r_size, r_signed, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata, r_merged;
    logic              w_err;
    logic [DATA_W-1:0] w_load, w_merged;

    assign w_err = (req_size == SZ_WORD && req_addr[0]) || (req_addr[ADDR_W-1:1] >= (ADDR_W-1)'(DEPTH));

    lsu_byte_lane u_lane (
        .i_word   (mem_read_data),
        .i_byte   (r_wdata[7:0]),
        .i_hi     (r_addr[0]),
        .i_signed (r_signed),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // state register
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    // next-state decode; errors skip the memory entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req_valid ? (w_err ? RESP : ACCESS) : IDLE;
            ACCESS:  w_next = (r_we && r_size == SZ_BYTE) ? RMW : RESP;
            RMW:     w_next = RESP;
            default: w_next = resp_ready ? IDLE : RESP;
        endcase
    end

    // request capture and load/merge data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_size   <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_merged <= '0;
        end else if (r_state == IDLE && req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_err    <= w_err;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
        end else if (r_state == ACCESS) begin
            if (!r_we) r_rdata <= (r_size == SZ_WORD) ? mem_read_data : w_load;
            r_merged <= w_merged;
        end
    end

    // outputs from state and registered fields; reset kills strobes in its own cycle
    always_comb begin
        req_ready       = r_state == IDLE;
        busy            = r_state != IDLE;
        resp_valid      = r_state == RESP;
        resp_rdata      = resp_valid ? r_rdata : '0;
        resp_err        = resp_valid && r_err;
        mem_access_addr = {1'b0, r_addr[ADDR_W-1:1]};
        mem_read        = !reset && r_state == ACCESS && (!r_we || r_size == SZ_BYTE);
        mem_write_en    = !reset && ((r_state == ACCESS && r_we && r_size == SZ_WORD) || r_state == RMW);
        mem_write_data  = (r_state == RMW) ? r_merged : (mem_write_en ? r_wdata : '0);
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a memory model
module tb_load_store_unit;
    logic        clk = 0, reset = 1;
    logic        req_valid = 0, req_we = 0, req_size = 0, req_signed = 0, resp_ready = 1;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_err, busy, mem_write_en, mem_read;
    logic [15:0] resp_rdata, mem_access_addr, mem_write_data, mem_read_data;
    logic [15:0] mem [8];
    int          model [8];
    int          wr_cnt = 0, rd_cnt = 0, ov_cnt = 0;
    logic [15:0] last_wa = 0, last_wd = 0;
    int          tests = 0, fails = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always_comb mem_read_data = (mem_access_addr < 16'd8) ? mem[mem_access_addr[2:0]] : 16'h0;

    always @(posedge clk) begin
        if (mem_write_en) begin
            if (mem_access_addr < 16'd8) mem[mem_access_addr[2:0]] <= mem_write_data;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_access_addr;
            last_wd <= mem_write_data;
        end
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_read && mem_write_en) ov_cnt <= ov_cnt + 1;
    end

    task automatic transact(input logic we, input logic sz, input logic sg, input logic [15:0] a,
                            input logic [15:0] wd, output logic [15:0] rd, output logic er,
                            output int lat, output int nw, output int nr);
        int w0, r0, t;
        @(negedge clk);
        req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        w0 = wr_cnt; r0 = rd_cnt; t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = resp_rdata; er = resp_err; nw = wr_cnt - w0; nr = rd_cnt - r0;
        @(posedge clk); #1;
    endtask

    task automatic ref_op(input logic we, input logic sz, input logic sg, input logic [15:0] a,
                          input logic [15:0] wd, output logic [15:0] rd, output logic er,
                          output int lat, output int nw, output int nr);
        int idx, v, b;
        idx = int'(a) / 2;
        er  = (sz && a[0]) || idx >= 8;
        rd  = 0; nw = 0; nr = 0;
        lat = er ? 1 : ((we && !sz) ? 3 : 2);
        if (!er) begin
            v = model[idx];
            b = (a[0] ? v / 256 : v) % 256;
            if (!we) begin
                nr = 1;
                rd = sz ? 16'(v) : 16'((sg && b >= 128) ? b + 'hFF00 : b);
            end else begin
                nw = 1;
                nr = sz ? 0 : 1;
                model[idx] = sz ? int'(wd) :
                             (a[0] ? (v % 256) + (int'(wd) % 256) * 256 : (v / 256) * 256 + int'(wd) % 256);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 || mem_write_en !== 1'b0 ||
            mem_read !== 1'b0 || resp_rdata !== 16'h0 || resp_err !== 1'b0 || mem_access_addr !== 16'h0 ||
            mem_write_data !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b we=%b rd=%b rdata=%h err=%b addr=%h wd=%h, need rdy=1 rest 0",
                     req_ready, resp_valid, busy, mem_write_en, mem_read, resp_rdata, resp_err, mem_access_addr, mem_write_data);
        end
    endtask

    task automatic test_word;
        logic [15:0] rd; logic er; int lat, nw, nr;
        transact(1, 1, 0, 16'h0006, 16'hBEEF, rd, er, lat, nw, nr);
        tests++;
        if (nw !== 1 || last_wa !== 16'd3 || last_wd !== 16'hBEEF || lat !== 2 || er !== 1'b0) begin
            fails++;
            $display("FAIL word_store: writes=%0d addr=%h data=%h lat=%0d err=%b, need 1 0003 BEEF 2 0", nw, last_wa, last_wd, lat, er);
        end
        transact(0, 1, 0, 16'h0006, 16'h0, rd, er, lat, nw, nr);
        tests++;
        if (rd !== 16'hBEEF || er !== 1'b0 || lat !== 2 || nw !== 0) begin
            fails++;
            $display("FAIL word_load: rdata=%h err=%b lat=%0d writes=%0d, need BEEF 0 2 0", rd, er, lat, nw);
        end
    endtask

    task automatic test_byte_load;
        logic [15:0] rd; logic er; int lat, nw, nr;
        transact(1, 1, 0, 16'h0004, 16'h12F0, rd, er, lat, nw, nr);
        transact(0, 0, 1, 16'h0004, 16'h0, rd, er, lat, nw, nr);
        tests++;
        if (rd !== 16'hFFF0 || er !== 1'b0 || lat !== 2) begin
            fails++;
            $display("FAIL byte_load_signed: rdata=%h err=%b lat=%0d, need FFF0 0 2", rd, er, lat);
        end
        transact(0, 0, 0, 16'h0005, 16'h0, rd, er, lat, nw, nr);
        tests++;
        if (rd !== 16'h0012 || er !== 1'b0) begin
            fails++;
            $display("FAIL byte_load_unsigned: rdata=%h err=%b, need 0012 0", rd, er);
        end
    endtask

    task automatic test_byte_store;
        logic [15:0] rd; logic er; int lat, nw, nr;
        transact(1, 1, 0, 16'h0002, 16'hAAAA, rd, er, lat, nw, nr);
        transact(1, 0, 0, 16'h0003, 16'h0055, rd, er, lat, nw, nr);
        tests++;
        if (mem[1] !== 16'h55AA || nr !== 1 || nw !== 1 || lat !== 3 || rd !== 16'h0) begin
            fails++;
            $display("FAIL byte_store: mem1=%h reads=%0d writes=%0d lat=%0d rdata=%h, need 55AA 1 1 3 0000", mem[1], nr, nw, lat, rd);
        end
    endtask

    task automatic test_errors;
        logic [15:0] rd; logic er; int lat, nw, nr;
        transact(0, 1, 0, 16'h0001, 16'h0, rd, er, lat, nw, nr);
        tests++;
        if (er !== 1'b1 || lat !== 1 || nr !== 0 || nw !== 0 || rd !== 16'h0) begin
            fails++;
            $display("FAIL misaligned_load: err=%b lat=%0d reads=%0d writes=%0d rdata=%h, need 1 1 0 0 0000", er, lat, nr, nw, rd);
        end
        transact(1, 1, 0, 16'h0010, 16'h1234, rd, er, lat, nw, nr);
        tests++;
        if (er !== 1'b1 || lat !== 1 || nw !== 0 || mem[0] === 16'h1234) begin
            fails++;
            $display("FAIL range_store: err=%b lat=%0d writes=%0d mem0=%h, need 1 1 0 untouched", er, lat, nw, mem[0]);
        end
        transact(0, 0, 0, 16'h000F, 16'h0, rd, er, lat, nw, nr);
        tests++;
        if (er !== 1'b0 || nr !== 1) begin
            fails++;
            $display("FAIL top_byte_in_range: err=%b reads=%0d, need 0 1", er, nr);
        end
    endtask

    task automatic test_hold;
        int t, w0;
        logic [15:0] held;
        logic bad;
        resp_ready = 0;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 1; req_signed = 0; req_addr = 16'h0006;
        @(posedge clk); #1 req_valid = 0;
        t = 0;
        while (!resp_valid && t < 20) begin @(posedge clk); #1; t++; end
        held = resp_rdata;
        w0 = wr_cnt;
        bad = 0;
        req_valid = 1; req_we = 1; req_size = 1; req_addr = 16'h0000; req_wdata = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 || busy !== 1'b1) bad = 1;
        end
        tests++;
        if (bad || held !== 16'hBEEF || wr_cnt !== w0) begin
            fails++;
            $display("FAIL resp_hold: unstable=%b rdata=%h writes=%0d, need 0 BEEF 0", bad, held, wr_cnt - w0);
        end
        req_valid = 0;
        resp_ready = 1;
        @(posedge clk); #1;
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || wr_cnt !== w0) begin
            fails++;
            $display("FAIL resp_release: rdy=%b vld=%b writes=%0d, need 1 0 0", req_ready, resp_valid, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd; logic er; int lat, nw, nr, w0;
        logic saw;
        transact(1, 1, 0, 16'h000A, 16'h1111, rd, er, lat, nw, nr);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 0; req_addr = 16'h000A; req_wdata = 16'h00EE;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1;
        saw = mem_write_en;
        w0 = wr_cnt;
        reset = 1;
        #1;
        tests++;
        if (saw !== 1'b1 || mem_write_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_rmw_strobe: rmw_we=%b we_in_reset=%b, need 1 0", saw, mem_write_en);
        end
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;
        tests++;
        if (wr_cnt !== w0 || mem[5] !== 16'h1111 || busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_rmw_state: writes=%0d mem5=%h busy=%b rdy=%b vld=%b, need 0 1111 0 1 0",
                     wr_cnt - w0, mem[5], busy, req_ready, resp_valid);
        end
        transact(0, 1, 0, 16'h000A, 16'h0, rd, er, lat, nw, nr);
        tests++;
        if (rd !== 16'h1111 || er !== 1'b0) begin
            fails++;
            $display("FAIL load_after_reset: rdata=%h err=%b, need 1111 0", rd, er);
        end
    endtask

    task automatic test_random;
        logic [15:0] rd, erd, a, wd; logic er, eer, we, sz, sg;
        int lat, elat, nw, enw, nr, enr, bad, o0;
        bad = 0;
        o0 = ov_cnt;
        for (int i = 0; i < 8; i++) begin
            wd = 16'($urandom);
            ref_op(1, 1, 0, 16'(2 * i), wd, erd, eer, elat, enw, enr);
            transact(1, 1, 0, 16'(2 * i), wd, rd, er, lat, nw, nr);
        end
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom); sz = 1'($urandom); sg = 1'($urandom);
            a = 16'($urandom_range(0, 19));
            wd = 16'($urandom);
            ref_op(we, sz, sg, a, wd, erd, eer, elat, enw, enr);
            transact(we, sz, sg, a, wd, rd, er, lat, nw, nr);
            tests++;
            if (rd !== erd || er !== eer || lat !== elat || nw !== enw || nr !== enr) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random_op %0d we=%b sz=%b sg=%b a=%h: rdata=%h err=%b lat=%0d w=%0d r=%0d, need %h %b %0d %0d %0d",
                             i, we, sz, sg, a, rd, er, lat, nw, nr, erd, eer, elat, enw, enr);
                bad++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (mem[i] !== 16'(model[i])) begin
                fails++;
                $display("FAIL random_mem[%0d]: got %h, need %h", i, mem[i], 16'(model[i]));
            end
        end
        tests++;
        if (ov_cnt !== o0) begin
            fails++;
            $display("FAIL read_write_overlap: got %0d cycles, need 0", ov_cnt - o0);
        end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte_load;
        test_byte_store;
        test_errors;
        test_hold;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
